serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder, LSB first, using a single full-adder cell and a carry flip-flop.
- Performs the inverse operation of the team's half-subtractor arithmetic cells, adding instead of subtracting.
- Trades WIDTH cycles of latency for minimal logic.
- Fronted by a start/busy/done handshake so a controller or bench can issue operands and collect Sum/Carry.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand A; captured on accepted start
- B  input  WIDTH  operand B; captured on accepted start
- Sum  output  WIDTH  registered result (A+B) mod 2^WIDTH
- Carry  output  1  registered carry-out of the MSB
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse when Sum/Carry update

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. Asserting rst forces all state immediately, independent of clk.
- Reset values: state=IDLE; Sum=0; Carry=0; busy=0; done=0; internal shift registers, carry flip-flop and bit counter all 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: capture A into shift register ra and B into rb, clear carry flip-flop c, set counter=0, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, each edge:
  - s = ra[0]^rb[0]^c; c <= majority(ra[0], rb[0], c).
  - s shifts into the MSB of partial-sum register rs; rs shifts right.
  - ra and rb shift right; counter increments.
  - The edge that processes bit WIDTH-1 (edge E0+WIDTH) goes to DONE and loads Sum<=final rs and Carry<=final c in the same edge.
- DONE:
  - Lasts one cycle; go to IDLE on the next edge.
  - start is ignored in DONE.
- Latency:
  - busy=1 from E0 until E0+WIDTH.
  - done=1 for exactly the one cycle following E0+WIDTH.
  - Next start is accepted no earlier than edge E0+WIDTH+1.
- Sum and Carry change only on entry to DONE and hold until the next completion. Partial results are never visible on the outputs.
- start while busy or in DONE: ignored, with no effect on the operation in progress. A and B may change freely after the accepting edge.
- Reset mid-operation: abort immediately; return to reset values. Previous Sum is cleared and no done pulse is produced.
- Wrap-around: the result is modulo 2^WIDTH, and the bit beyond the MSB appears only on Carry.

Optional Feature:
- Macro: OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port Ovf (1 bit), the signed two's-complement overflow.
  - Ovf = carry into MSB XOR carry out of MSB.
  - Registered, updated on entry to DONE together with Sum, reset to 0.
- Undefined: Ovf port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- rst pulse mid-cycle, asynchronously, with clk stopped -> Sum=0x00, Carry=0, busy=0, done=0 immediately.
- A=0x0F, B=0x01, start 1 cycle -> busy for 8 cycles, then done pulse of exactly 1 cycle; Sum=0x10, Carry=0 (Ovf=0).
- A=0xFF, B=0x01 -> Sum=0x00, Carry=1 (Ovf=0). A=0x7F, B=0x01 -> Sum=0x80, Carry=0 (Ovf=1).
- Start A=0x55, B=0xAA; 3 cycles later start=1 with A=0x01, B=0x01 -> ignored; result Sum=0xFF, Carry=0; done pulses once.
- Start A=0x80, B=0x80; assert rst at cycle 4 -> no done pulse, Sum=0x00, Carry=0. Release rst, start A=0x80, B=0x80 -> Sum=0x00, Carry=1 (Ovf=1).
- Hold start=1 continuously with A=0x01, B=0x02 -> operations complete every 10 cycles (8 busy, 1 DONE, 1 IDLE accept); each gives Sum=0x03, and start is never accepted during DONE.

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder, LSB first. One full-adder cell plus a
//            carry flip-flop processes one bit per clock, so an add takes WIDTH
//            cycles. A start/busy/done handshake frames each operation.
// Ports    : clk    - rising-edge clock
//            rst    - asynchronous, active-high reset
//            start  - request, sampled only while idle
//            A, B   - operands, captured on the accepting edge
//            Sum    - registered (A+B) mod 2^WIDTH
//            Carry  - registered carry-out of the MSB
//            Ovf    - registered signed overflow (only with OVERFLOW_FLAG_EN)
//            busy   - high while bits are being shifted through the adder
//            done   - one-cycle pulse in the cycle after Sum/Carry update
// Options  : define OVERFLOW_FLAG_EN to add the Ovf output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
`ifdef OVERFLOW_FLAG_EN
  output logic             Ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] ra, rb, rs;
  logic             c;
  logic [CW-1:0]    cnt;

  // Single full-adder cell operating on the current LSBs.
  logic             s, cout;
  logic [WIDTH-1:0] rs_next;

  assign s       = ra[0] ^ rb[0] ^ c;
  assign cout    = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  assign rs_next = {s, rs[WIDTH-1:1]};

  // rs[0] is shifted out past the LSB and never needed.
  logic unused_rs_lsb;
  assign unused_rs_lsb = rs[0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand shifters, carry flop, partial sum and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Carry <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      Ovf   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ra  <= A;
            rb  <= B;
            rs  <= '0;
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rs  <= rs_next;
          c   <= cout;
          cnt <= cnt + CW'(1);
          // Results become visible only once the MSB has been processed.
          if (cnt == LAST_BIT) begin
            Sum   <= rs_next;
            Carry <= cout;
`ifdef OVERFLOW_FLAG_EN
            // c is the carry into the MSB, cout the carry out of it.
            Ovf   <= c ^ cout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder (WIDTH=8). Directed cases
//            plus randomized operands compared with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  bit               clk_run = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             busy;
  logic             done;
`ifdef OVERFLOW_FLAG_EN
  logic             Ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Sum   (Sum),
    .Carry (Carry),
`ifdef OVERFLOW_FLAG_EN
    .Ovf   (Ovf),
`endif
    .busy  (busy),
    .done  (done)
  );

  always #5 if (clk_run) clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one add from IDLE and follow it to completion. If intr > 0, a
  // second start (A=B=1) is driven while the first operation is busy.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int intr);
    logic [WIDTH:0]   full;
    logic             ovf_exp;
    logic [WIDTH-1:0] sum_before;
    int               n, nb;
    bit               held;
    full       = {1'b0, a} + {1'b0, b};
    ovf_exp    = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    sum_before = Sum;
    start = 1'b1; A = a; B = b;
    cyc();
    start = 1'b0;
    A = WIDTH'($urandom);
    B = WIDTH'($urandom);
    n = 0; nb = 0; held = 1'b1;
    while (done !== 1'b1 && n < 3 * WIDTH) begin
      if (busy === 1'b1) nb++;
      if (Sum !== sum_before) held = 1'b0;
      if (intr > 0 && n == intr) begin
        start = 1'b1; A = 1; B = 1;
      end
      cyc();
      start = 1'b0;
      n++;
    end
    check("latency", 32'(n), 32'(WIDTH));
    check("busy_cycles", 32'(nb), 32'(WIDTH));
    check("sum_held_during_op", 32'(held), 32'd1);
    check("sum", 32'(Sum), 32'(full[WIDTH-1:0]));
    check("carry", 32'(Carry), 32'(full[WIDTH]));
`ifdef OVERFLOW_FLAG_EN
    check("ovf", 32'(Ovf), 32'(ovf_exp));
`else
    if (ovf_exp) ; // flag not present in this build
`endif
    check("busy_in_done", 32'(busy), 32'd0);
    cyc();
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int  last, dcnt;
    bit  prev_done, saw_done;

    rst = 1'b0; start = 1'b0; A = '0; B = '0;

    // Asynchronous reset with the clock stopped.
    #3 rst = 1'b1;
    #1;
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_carry", 32'(Carry), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    check("rst_ovf", 32'(Ovf), 32'd0);
`endif
    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Directed cases.
    issue(8'h0F, 8'h01, 0);
    issue(8'hFF, 8'h01, 0);
    issue(8'h7F, 8'h01, 0);

    // Start during busy must be ignored: result is 0x55+0xAA.
    issue(8'h55, 8'hAA, 3);
    check("ignored_start_sum", 32'(Sum), 32'h0FF);

    // Reset mid-operation.
    start = 1'b1; A = 8'h80; B = 8'h80;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    #2 rst = 1'b1;
    #1;
    check("midrst_sum", 32'(Sum), 32'd0);
    check("midrst_carry", 32'(Carry), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      cyc();
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    issue(8'h80, 8'h80, 0);

    // Continuous start: one completion every WIDTH+2 cycles.
    start = 1'b1; A = 8'h01; B = 8'h02;
    last = -1; dcnt = 0; prev_done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      cyc();
      if (prev_done) check("no_accept_in_done", 32'(busy), 32'd0);
      if (done === 1'b1) begin
        check("hold_sum", 32'(Sum), 32'h03);
        if (last >= 0) check("hold_period", 32'(i - last), 32'(WIDTH + 2));
        last = i;
        dcnt++;
      end
      prev_done = (done === 1'b1);
    end
    check("hold_done_count", 32'(dcnt), 32'd4);
    start = 1'b0;
    repeat (3 * WIDTH) cyc();

    // Randomized operands against the arithmetic model.
    for (int k = 0; k < 20; k++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
